// File: rtl/mem_lsu.sv
// Memory load/store unit: turns one ex/mem memory operation into a single
// word-wide bus transaction and produces the extended writeback value.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [4:0]  wb_waddr,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stall_req,
    output logic        align_err
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      eff_state_s;
    logic [3:0]  op_r;
    logic [1:0]  off_r;
    logic [31:0] rdata_r;
    logic [3:0]  op_s;
    logic        misalign_s;

    // Unused encodings behave exactly like "no access".
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        norm_op = (op > OP_SW) ? OP_NONE : op;
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_misaligned = off[0];
            OP_LW, OP_SW:         op_misaligned = |off;
            default:              op_misaligned = 1'b0;
        endcase
    endfunction

    // Big-endian lanes: byte offset 0 is the most significant byte.
    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   lane_sel = 4'b1000 >> off;
            OP_SH:   lane_sel = off[1] ? 4'b0011 : 4'b1100;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sdata);
        case (op)
            OP_SB:   store_data = {4{sdata[7:0]}};
            OP_SH:   store_data = {2{sdata[15:0]}};
            OP_SW:   store_data = sdata;
            default: store_data = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (op)
            OP_LB:   load_extend = {{24{b[7]}}, b};
            OP_LBU:  load_extend = {24'd0, b};
            OP_LH:   load_extend = {{16{h[15]}}, h};
            OP_LHU:  load_extend = {16'd0, h};
            OP_LW:   load_extend = rdata;
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign op_s       = norm_op(mem_op);
    assign misalign_s = op_misaligned(op_s, mem_addr[1:0]);

    // Access sequencing and registered bus master outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
            op_r      <= OP_NONE;
            off_r     <= 2'd0;
            rdata_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((op_s != OP_NONE) && !misalign_s) begin
                        state_r   <= ST_BUSY;
                        bus_req   <= 1'b1;
                        bus_we    <= !op_is_load(op_s);
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_sel   <= lane_sel(op_s, mem_addr[1:0]);
                        bus_wdata <= store_data(op_s, mem_sdata);
                        op_r      <= op_s;
                        off_r     <= mem_addr[1:0];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Bus fields stay put after the ack; only the request drops.
                    if (bus_ack) begin
                        rdata_r <= bus_rdata;
                        bus_req <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Writeback, stall and alignment flags; reset presents the IDLE behaviour.
    always_comb begin
        if (rst) begin
            eff_state_s = ST_IDLE;
        end else begin
            eff_state_s = state_r;
        end
        wb_waddr  = mem_waddr;
        wb_wreg   = 1'b0;
        wb_wdata  = mem_wdata;
        stall_req = 1'b0;
        align_err = 1'b0;
        case (eff_state_s)
            ST_IDLE: begin
                if (op_s == OP_NONE) begin
                    wb_wreg = mem_wreg;
                end else if (misalign_s) begin
                    align_err = 1'b1;
                end else begin
                    stall_req = 1'b1;
                end
            end
            ST_BUSY: begin
                stall_req = 1'b1;
            end
            ST_DONE: begin
                wb_wreg = mem_wreg;
                if (op_is_load(op_r)) begin
                    wb_wdata = load_extend(op_r, off_r, rdata_r);
                end else begin
                    wb_wdata = mem_wdata;
                end
            end
            default: begin
                wb_wreg = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed, table-driven checks for mem_lsu plus hand-written corner sequences.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_waddr;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [4:0]  wb_waddr;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stall_req;
    logic        align_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[16];

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .mem_waddr(mem_waddr), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wb_waddr(wb_waddr), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stall_req(stall_req), .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, wanted $finish)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input int idx, input vec_t v);
        logic is_store;
        is_store  = (v.op >= 4'd6);
        mem_op    = v.op;
        mem_addr  = v.addr;
        mem_sdata = v.sdata;
        mem_waddr = 5'd9;
        mem_wreg  = 1'b1;
        mem_wdata = 32'hDEAD_BEEF;
        bus_ack   = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
        #1;
        chk($sformatf("v%0d idle stall", idx), {31'd0, stall_req}, 32'd1);
        chk($sformatf("v%0d idle wreg", idx), {31'd0, wb_wreg}, 32'd0);
        chk($sformatf("v%0d idle align", idx), {31'd0, align_err}, 32'd0);
        tick();
        for (int c = 0; c <= v.delay; c++) begin
            chk($sformatf("v%0d b%0d req", idx, c), {31'd0, bus_req}, 32'd1);
            chk($sformatf("v%0d b%0d addr", idx, c), bus_addr, v.exp_addr);
            chk($sformatf("v%0d b%0d we", idx, c), {31'd0, bus_we}, {31'd0, v.exp_we});
            chk($sformatf("v%0d b%0d sel", idx, c), {28'd0, bus_sel}, {28'd0, v.exp_sel});
            if (is_store) begin
                chk($sformatf("v%0d b%0d wdata", idx, c), bus_wdata, v.exp_wdata);
            end
            chk($sformatf("v%0d b%0d stall", idx, c), {31'd0, stall_req}, 32'd1);
            chk($sformatf("v%0d b%0d wreg", idx, c), {31'd0, wb_wreg}, 32'd0);
            if (c == v.delay) begin
                bus_ack   = 1'b1;
                bus_rdata = v.rdata;
            end
            tick();
        end
        // DONE: stray ack must be ignored and op stays present
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        chk($sformatf("v%0d done req", idx), {31'd0, bus_req}, 32'd0);
        chk($sformatf("v%0d done stall", idx), {31'd0, stall_req}, 32'd0);
        chk($sformatf("v%0d done wreg", idx), {31'd0, wb_wreg}, 32'd1);
        chk($sformatf("v%0d done waddr", idx), {27'd0, wb_waddr}, 32'd9);
        chk($sformatf("v%0d done wdata", idx), wb_wdata, v.exp_wb);
        tick();
        bus_ack = 1'b0;
        chk($sformatf("v%0d after req", idx), {31'd0, bus_req}, 32'd0);
        mem_op = 4'd0;
        #1;
        chk($sformatf("v%0d after stall", idx), {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'h101, 32'h0,        32'h11F2_3344, 0, 32'h100, 1'b0, 4'hF, 32'h0,        32'hFFFF_FFF2};
        vecs[1]  = '{4'd2, 32'h101, 32'h0,        32'h11F2_3344, 0, 32'h100, 1'b0, 4'hF, 32'h0,        32'h0000_00F2};
        vecs[2]  = '{4'd7, 32'h22,  32'hABCD,     32'h0,         3, 32'h20,  1'b1, 4'h3, 32'hABCD_ABCD, 32'hDEAD_BEEF};
        vecs[3]  = '{4'd6, 32'h13,  32'h1234_56A5, 32'h0,        1, 32'h10,  1'b1, 4'h1, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
        vecs[4]  = '{4'd6, 32'h10,  32'h5A,       32'h0,         0, 32'h10,  1'b1, 4'h8, 32'h5A5A_5A5A, 32'hDEAD_BEEF};
        vecs[5]  = '{4'd3, 32'h200, 32'h0,        32'h8001_7FFF, 2, 32'h200, 1'b0, 4'hF, 32'h0,        32'hFFFF_8001};
        vecs[6]  = '{4'd3, 32'h202, 32'h0,        32'h8001_7FFF, 0, 32'h200, 1'b0, 4'hF, 32'h0,        32'h0000_7FFF};
        vecs[7]  = '{4'd5, 32'h44,  32'h0,        32'hCAFE_BABE, 1, 32'h44,  1'b0, 4'hF, 32'h0,        32'hCAFE_BABE};
        vecs[8]  = '{4'd8, 32'h48,  32'h0123_4567, 32'h0,        0, 32'h48,  1'b1, 4'hF, 32'h0123_4567, 32'hDEAD_BEEF};
        vecs[9]  = '{4'd1, 32'h303, 32'h0,        32'h11F2_3380, 0, 32'h300, 1'b0, 4'hF, 32'h0,        32'hFFFF_FF80};
        vecs[10] = '{4'd7, 32'h0,   32'hFFFF_1234, 32'h0,        0, 32'h0,   1'b1, 4'hC, 32'h1234_1234, 32'hDEAD_BEEF};
        vecs[11] = '{4'd8, 32'h4,   32'h1122_3344, 32'h0,        0, 32'h4,   1'b1, 4'hF, 32'h1122_3344, 32'hDEAD_BEEF};
        vecs[12] = '{4'd4, 32'h2,   32'h0,        32'h0000_8001, 0, 32'h0,   1'b0, 4'hF, 32'h0,        32'h0000_8001};
        vecs[13] = '{4'd6, 32'h12,  32'h77,       32'h0,         0, 32'h10,  1'b1, 4'h2, 32'h7777_7777, 32'hDEAD_BEEF};
        vecs[14] = '{4'd2, 32'h102, 32'h0,        32'h11F2_3344, 0, 32'h100, 1'b0, 4'hF, 32'h0,        32'h0000_0033};
        vecs[15] = '{4'd4, 32'h100, 32'h0,        32'hFEDC_0000, 2, 32'h100, 1'b0, 4'hF, 32'h0,        32'h0000_FEDC};

        rst = 1'b1;
        mem_waddr = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
        mem_op = 4'd0; mem_addr = 32'd0; mem_sdata = 32'd0;
        bus_rdata = 32'd0; bus_ack = 1'b0;
        tick();
        tick();
        chk("rst req", {31'd0, bus_req}, 32'd0);
        chk("rst we", {31'd0, bus_we}, 32'd0);
        chk("rst addr", bus_addr, 32'd0);
        chk("rst sel", {28'd0, bus_sel}, 32'd0);
        chk("rst wdata", bus_wdata, 32'd0);
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;
        tick();

        // Pass-through, including an unused op code
        mem_waddr = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
        #1;
        chk("pt waddr", {27'd0, wb_waddr}, 32'd5);
        chk("pt wreg", {31'd0, wb_wreg}, 32'd1);
        chk("pt wdata", wb_wdata, 32'h1234);
        chk("pt stall", {31'd0, stall_req}, 32'd0);
        mem_op = 4'd12; mem_addr = 32'h3;
        #1;
        chk("op12 wreg", {31'd0, wb_wreg}, 32'd1);
        chk("op12 stall", {31'd0, stall_req}, 32'd0);
        chk("op12 align", {31'd0, align_err}, 32'd0);
        tick();
        chk("op12 noreq", {31'd0, bus_req}, 32'd0);

        // Misaligned LW and LH: flag only, no bus activity
        mem_op = 4'd5; mem_addr = 32'h3;
        #1;
        chk("mis lw align", {31'd0, align_err}, 32'd1);
        chk("mis lw stall", {31'd0, stall_req}, 32'd0);
        chk("mis lw wreg", {31'd0, wb_wreg}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mis lw req%0d", i), {31'd0, bus_req}, 32'd0);
            chk($sformatf("mis lw align%0d", i), {31'd0, align_err}, 32'd1);
        end
        mem_op = 4'd4; mem_addr = 32'h101;
        #1;
        chk("mis lhu align", {31'd0, align_err}, 32'd1);
        tick();
        chk("mis lhu req", {31'd0, bus_req}, 32'd0);
        mem_op = 4'd0;
        #1;

        for (int i = 0; i < 16; i++) begin
            run_access(i, vecs[i]);
        end

        // Reset in the second BUSY cycle of an LW, then a late ack
        mem_op = 4'd5; mem_addr = 32'h8; mem_wreg = 1'b1; mem_wdata = 32'h0000_1111;
        tick();
        chk("ra busy1 req", {31'd0, bus_req}, 32'd1);
        tick();
        chk("ra busy2 req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        mem_op = 4'd0;
        #1;
        chk("ra rst stall", {31'd0, stall_req}, 32'd0);
        chk("ra rst wreg", {31'd0, wb_wreg}, 32'd1);
        tick();
        chk("ra post req", {31'd0, bus_req}, 32'd0);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        tick();
        bus_ack = 1'b0;
        chk("ra late req", {31'd0, bus_req}, 32'd0);
        chk("ra late stall", {31'd0, stall_req}, 32'd0);
        chk("ra late wdata", wb_wdata, 32'h0000_1111);
        tick();
        chk("ra idle req", {31'd0, bus_req}, 32'd0);
        chk("ra idle wdata", wb_wdata, 32'h0000_1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
